// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: widths, reset default, FSM encoding
// and the redirect record used by both the target calculator and the sequencer.
package pc_sequencer_pkg;

    localparam int XLEN    = 32;
    localparam int JADDR_W = 26;
    localparam int BOFF_W  = 16;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } redirect_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target calculation (branch, jump, register jump)
// with fixed priority JR > J > branch.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic               branch_taken,
    input  logic [BOFF_W-1:0]  branch_offset,
    input  logic               jump_en,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic               jr_en,
    input  logic [XLEN-1:0]    jr_addr,
    output redirect_t          redirect
);

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] jr_target;

    // Word offset: sign-extend, then scale by 4; addition wraps naturally.
    assign branch_target = pc_plus4 +
        {{(XLEN-BOFF_W-2){branch_offset[BOFF_W-1]}}, branch_offset, 2'b00};
    assign jump_target   = (pc_plus4 & 32'hF000_0000) | {4'b0000, jump_addr, 2'b00};
    assign jr_target     = jr_addr & {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        redirect = '0;
        if (jr_en) begin
            redirect.valid  = 1'b1;
            redirect.target = jr_target;
        end else if (jump_en) begin
            redirect.valid  = 1'b1;
            redirect.target = jump_target;
        end else if (branch_taken) begin
            redirect.valid  = 1'b1;
            redirect.target = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: IDLE/FETCH/HOLD FSM driving the instruction-memory
// handshake, with a one-deep pending redirect register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [BOFF_W-1:0]  BranchOffset,
    input  logic               JumpEn,
    input  logic [JADDR_W-1:0] JumpAddr,
    input  logic               JrEn,
    input  logic [XLEN-1:0]    JrAddr,
    output logic               ImemReq,
    output logic [XLEN-1:0]    ImemAddr,
    input  logic               ImemReady,
    output logic [XLEN-1:0]    Pc,
    output logic [XLEN-1:0]    PcPlus4,
    output logic               FetchValid,
    output seq_state_e         state
);

    // Handshake: a fetch is accepted on any cycle where ImemReq and ImemReady
    // are both high; ImemAddr holds Pc, which only changes on accept.
    redirect_t redirect;
    redirect_t pending;
    logic      sample;
    logic      redir_valid;
    logic      accept;

    pc_target_calc u_target_calc (
        .pc_plus4      (PcPlus4),
        .branch_taken  (BranchTaken),
        .branch_offset (BranchOffset),
        .jump_en       (JumpEn),
        .jump_addr     (JumpAddr),
        .jr_en         (JrEn),
        .jr_addr       (JrAddr),
        .redirect      (redirect)
    );

    assign PcPlus4     = Pc + 32'd4;
    assign ImemAddr    = Pc;
    assign sample      = (state != ST_IDLE);
    assign redir_valid = sample && redirect.valid;
    // Stall withdraws the request in the same cycle so it always beats ImemReady.
    assign ImemReq     = (state == ST_FETCH) && !Stall;
    assign accept      = ImemReq && ImemReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            Pc         <= RESET_PC;
            pending    <= '0;
            FetchValid <= 1'b0;
        end else begin
            FetchValid <= 1'b0;
            unique case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (Stall) state <= ST_HOLD;
                ST_HOLD:  if (!Stall) state <= ST_FETCH;
                default:  state <= ST_IDLE;
            endcase

            if (accept) begin
                pending <= '0;
                if (redir_valid) begin
                    Pc <= redirect.target;
                end else if (pending.valid) begin
                    // The fetch in flight belongs to the old path: drop it.
                    Pc <= pending.target;
                end else begin
                    Pc         <= PcPlus4;
                    FetchValid <= 1'b1;
                end
            end else if (redir_valid) begin
                pending <= redirect;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// checked against an abstract reference model and a delivered-fetch scoreboard.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, Stall, BranchTaken, JumpEn, JrEn, ImemReady;
    logic [15:0] BranchOffset;
    logic [25:0] JumpAddr;
    logic [31:0] JrAddr;
    logic        ImemReq, FetchValid;
    logic [31:0] ImemAddr, Pc, PcPlus4;
    seq_state_e  dut_state;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .JumpEn       (JumpEn),
        .JumpAddr     (JumpAddr),
        .JrEn         (JrEn),
        .JrAddr       (JrAddr),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .Pc           (Pc),
        .PcPlus4      (PcPlus4),
        .FetchValid   (FetchValid),
        .state        (dut_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected Pc value shown alongside each FetchValid pulse.
    logic [31:0] exp_q[$];

    // Reference model state, advanced once per rising edge.
    logic [31:0] m_pc = '0;
    logic [31:0] m_pend_tgt = '0;
    bit          m_pend = 0;
    bit          m_idle = 1;
    bit          m_held = 0;
    bit          m_known = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] pc4;
        logic [31:0] tgt;
        bit          have;
        bit          acc;
        if (reset) begin
            m_pc = RST_PC; m_idle = 1; m_held = 0; m_pend = 0; m_known = 1;
            return;
        end
        if (!m_known) return;
        if (m_idle) begin
            m_idle = 0;
            return;
        end
        pc4  = m_pc + 32'd4;
        have = 1;
        tgt  = '0;
        if (JrEn)             tgt = JrAddr & 32'hFFFF_FFFC;
        else if (JumpEn)      tgt = (pc4 & 32'hF000_0000) | (32'(JumpAddr) * 32'd4);
        else if (BranchTaken) tgt = pc4 + 32'(int'($signed(BranchOffset)) * 4);
        else                  have = 0;
        acc = !m_held && !Stall && ImemReady;
        if (acc) begin
            if (have)        m_pc = tgt;
            else if (m_pend) m_pc = m_pend_tgt;
            else begin
                m_pc = pc4;
                exp_q.push_back(pc4);
            end
            m_pend = 0;
        end else if (have) begin
            m_pend     = 1;
            m_pend_tgt = tgt;
        end
        // Fetching stops while Stall is high and resumes the cycle after it drops.
        m_held = Stall;
    endtask

    task automatic step(bit rst, bit stl, bit rdy, bit bt, logic [15:0] off,
                        bit je, logic [25:0] ja, bit jre, logic [31:0] jra);
        reset = rst; Stall = stl; ImemReady = rdy;
        BranchTaken = bt; BranchOffset = off;
        JumpEn = je; JumpAddr = ja; JrEn = jre; JrAddr = jra;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic plain(bit rdy);
        step(0, 0, rdy, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic jr_to(logic [31:0] a);
        step(0, 0, 1, 0, 16'h0, 0, 26'h0, 1, a);
    endtask

    // Monitor: per-cycle checks against the model plus the delivered-fetch scoreboard.
    initial forever begin
        @(negedge clk);
        if (m_known) begin
            check("pc", Pc, m_pc);
            check("imem_addr", ImemAddr, m_pc);
            check("pc_plus4", PcPlus4, m_pc + 32'd4);
            check("imem_req", 32'(ImemReq), 32'(!m_idle && !m_held && !Stall));
            if (FetchValid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL fetch_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    check("fetch_pc", Pc, exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                n_tests++; n_fail++;
                $display("FAIL fetch_valid: got 0 expected 1 at %0t", $time);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a late ImemReady that must be ignored.
        step(1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        check("rst_pc", Pc, RST_PC);
        check("rst_fv", 32'(FetchValid), 32'd0);
        check("rst_state", 32'(dut_state), 32'(ST_IDLE));

        // Ready tied high: sequential fetches 0, 4, 8.
        plain(1);
        check("idle_exit_addr", ImemAddr, 32'h0);
        check("idle_exit_req", 32'(ImemReq), 32'd1);
        plain(1);
        check("seq0_addr", ImemAddr, 32'h4);
        check("seq0_fv", 32'(FetchValid), 32'd1);
        plain(1);
        check("seq1_addr", ImemAddr, 32'h8);
        check("seq1_fv", 32'(FetchValid), 32'd1);
        plain(1);
        check("seq2_addr", ImemAddr, 32'hC);

        // Backward branch accepted in the same cycle.
        jr_to(32'h100);
        check("jr100_pc", Pc, 32'h100);
        check("jr100_fv", 32'(FetchValid), 32'd0);
        step(0, 0, 1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        check("br_back_pc", Pc, 32'h0FC);
        check("br_back_fv", 32'(FetchValid), 32'd0);

        // Jump then JR while waiting: newest wins, flushed fetch not delivered.
        jr_to(32'h200);
        step(0, 0, 0, 0, 16'h0, 1, 26'h40, 0, 32'h0);
        step(0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h1003);
        plain(0);
        check("wait_addr", ImemAddr, 32'h200);
        plain(1);
        check("pend_pc", Pc, 32'h1000);
        check("pend_fv", 32'(FetchValid), 32'd0);

        // Stall beats ImemReady.
        jr_to(32'h40);
        step(0, 1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        check("stall_pc", Pc, 32'h40);
        check("stall_fv", 32'(FetchValid), 32'd0);
        step(0, 1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        check("hold_state", 32'(dut_state), 32'(ST_HOLD));
        check("hold_req", 32'(ImemReq), 32'd0);
        plain(1);
        check("unstall_pc", Pc, 32'h40);
        check("unstall_req", 32'(ImemReq), 32'd1);
        plain(1);
        check("resume_pc", Pc, 32'h44);
        check("resume_fv", 32'(FetchValid), 32'd1);

        // Top-of-memory wrap, JR low bits forced to zero.
        jr_to(32'hFFFF_FFFE);
        check("top_pc", Pc, 32'hFFFF_FFFC);
        plain(1);
        check("wrap_pc", Pc, 32'h0);
        check("wrap_fv", 32'(FetchValid), 32'd1);
        plain(1);
        plain(0);
        step(1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        check("midrst_pc", Pc, RST_PC);
        check("midrst_fv", 32'(FetchValid), 32'd0);
        check("midrst_req", 32'(ImemReq), 32'd0);
        plain(1);
        check("late_ready_pc", Pc, RST_PC);
        check("late_ready_fv", 32'(FetchValid), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 9) == 0, 26'($urandom),
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                             : 32'($urandom));
        end
        plain(0);
        plain(0);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
